// File: rtl/fht_ctrl_pkg.sv
// Shared types and helpers for the FHT frame sequencer.
package fht_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitLo,
    StWaitHi,
    StRdIssue,
    StRdWait,
    StRdShift
  } state_e;

  // Cycles RDY may stay high after START before the transform counts as finished.
  localparam int unsigned RDY_TIMEOUT = 4;

  function automatic logic [1:0] bank_map(input logic [1:0] idx, input bit rev);
    return rev ? {idx[0], idx[1]} : idx;
  endfunction

endpackage

// File: rtl/fht_frame_ctrl_if.sv
// Result word stream (valid/ready) leaving the frame sequencer.
interface fht_frame_ctrl_if #(
  parameter int unsigned D_BIT = 16
) ();
  logic [D_BIT-1:0] oDATA;
  logic             oDATA_VALID;
  logic             iDATA_READY;
  logic             oLAST;

  modport master (output oDATA, oDATA_VALID, oLAST, input iDATA_READY);
  modport slave  (input oDATA, oDATA_VALID, oLAST, output iDATA_READY);
endinterface

// File: rtl/fht_rd_serializer.sv
// Holds one address group (four bank words) and shifts it out in sample-index order.
module fht_rd_serializer
  import fht_ctrl_pkg::*;
#(
  parameter int unsigned D_BIT    = 16,
  parameter int unsigned BANK_REV = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [3:0][D_BIT-1:0] words_i,
  input  logic                  last_group_i,
  fht_frame_ctrl_if.master      out_if,
  output logic                  done_o
);

  logic [3:0][D_BIT-1:0] hold_q;
  logic [1:0]            b_q;
  logic                  valid_q;
  logic                  last_grp_q;
  logic                  xfer;

  assign xfer               = valid_q & out_if.iDATA_READY;
  assign done_o             = xfer & (b_q == 2'd3);
  assign out_if.oDATA_VALID = valid_q;
  // Word b of the group was loaded into bank bank_map(b), so read it back from there.
  assign out_if.oDATA       = hold_q[bank_map(b_q, BANK_REV != 0)];
  assign out_if.oLAST       = valid_q & last_grp_q & (b_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      b_q        <= '0;
      valid_q    <= 1'b0;
      last_grp_q <= 1'b0;
    end else if (load_i) begin
      hold_q     <= words_i;
      b_q        <= '0;
      valid_q    <= 1'b1;
      last_grp_q <= last_group_i;
    end else if (xfer) begin
      b_q <= b_q + 1'b1;
      if (b_q == 2'd3) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fht_frame_ctrl.sv
// Frame sequencer around fht_top: loads ADC samples into the four banks, starts the
// transform, waits for completion and streams the results out in natural order.
module fht_frame_ctrl
  import fht_ctrl_pkg::*;
#(
  parameter int unsigned A_BIT    = 8,
  parameter int unsigned D_BIT    = 16,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned BANK_REV = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iEN,
  input  logic [D_BIT-2:0] iADC_DATA,
  input  logic             iADC_VALID,
  input  logic             iCLR_OVR,
  output logic [D_BIT-2:0] oFHT_DATA,
  output logic [A_BIT-1:0] oFHT_ADDR_WR,
  output logic [3:0]       oFHT_WE,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic [A_BIT-1:0] oFHT_ADDR_RD,
  input  logic [D_BIT-1:0] iFHT_DATA_0,
  input  logic [D_BIT-1:0] iFHT_DATA_1,
  input  logic [D_BIT-1:0] iFHT_DATA_2,
  input  logic [D_BIT-1:0] iFHT_DATA_3,
  fht_frame_ctrl_if.master res_if,
  output logic             oBUSY,
  output logic             oOVERRUN,
  output logic [15:0]      oFRAME_CNT
);

  state_e             state_q, state_d;
  logic [A_BIT+1:0]   k_q, k_d;
  logic [A_BIT-1:0]   a_q, a_d;
  logic [7:0]         lat_q, lat_d;
  logic [2:0]         to_q, to_d;
  logic [D_BIT-2:0]   data_q, data_d;
  logic [A_BIT-1:0]   addr_wr_q, addr_wr_d;
  logic [3:0]         we_q, we_d;
  logic               start_q, start_d;
  logic [A_BIT-1:0]   addr_rd_q, addr_rd_d;
  logic               ovr_q, ovr_d;
  logic [15:0]        frame_q, frame_d;
  logic               ser_load;
  logic               ser_done;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    lat_d     = lat_q;
    to_d      = to_q;
    data_d    = data_q;
    addr_wr_d = addr_wr_q;
    we_d      = 4'b0000;
    start_d   = 1'b0;
    addr_rd_d = addr_rd_q;
    frame_d   = frame_q;
    ser_load  = 1'b0;
    ovr_d     = ovr_q;
    if (iCLR_OVR) ovr_d = 1'b0;
    if (iADC_VALID && (state_q != StLoad)) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: if (iEN) state_d = StLoad;
      StLoad: begin
        if (iADC_VALID) begin
          data_d    = iADC_DATA;
          addr_wr_d = k_q[A_BIT+1:2];
          we_d      = 4'b0001 << bank_map(k_q[1:0], BANK_REV != 0);
          if (k_q == '1) begin
            k_d     = '0;
            state_d = StStart;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StStart: begin
        start_d = 1'b1;
        to_d    = '0;
        state_d = StWaitLo;
      end
      // A transform that never drops RDY is treated as already finished.
      StWaitLo: begin
        if (!iFHT_RDY || (to_q == 3'(RDY_TIMEOUT - 1))) state_d = StWaitHi;
        else to_d = to_q + 1'b1;
      end
      StWaitHi: begin
        if (iFHT_RDY) begin
          frame_d = frame_q + 16'd1;
          a_d     = '0;
          state_d = StRdIssue;
        end
      end
      StRdIssue: begin
        addr_rd_d = a_q;
        lat_d     = '0;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (lat_q == 8'(RD_LAT)) begin
          ser_load = 1'b1;
          state_d  = StRdShift;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRdShift: begin
        if (ser_done) begin
          if (a_q == '1) begin
            a_d     = '0;
            state_d = iEN ? StLoad : StIdle;
          end else begin
            a_d     = a_q + 1'b1;
            state_d = StRdIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= StIdle;
      k_q       <= '0;
      a_q       <= '0;
      lat_q     <= '0;
      to_q      <= '0;
      data_q    <= '0;
      addr_wr_q <= '0;
      we_q      <= '0;
      start_q   <= 1'b0;
      addr_rd_q <= '0;
      ovr_q     <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      lat_q     <= lat_d;
      to_q      <= to_d;
      data_q    <= data_d;
      addr_wr_q <= addr_wr_d;
      we_q      <= we_d;
      start_q   <= start_d;
      addr_rd_q <= addr_rd_d;
      ovr_q     <= ovr_d;
      frame_q   <= frame_d;
    end
  end

  fht_rd_serializer #(
    .D_BIT    (D_BIT),
    .BANK_REV (BANK_REV)
  ) u_ser (
    .clk_i        (iCLK),
    .rst_i        (iRESET),
    .load_i       (ser_load),
    .words_i      ({iFHT_DATA_3, iFHT_DATA_2, iFHT_DATA_1, iFHT_DATA_0}),
    .last_group_i (a_q == '1),
    .out_if       (res_if),
    .done_o       (ser_done)
  );

  assign oFHT_DATA    = data_q;
  assign oFHT_ADDR_WR = addr_wr_q;
  assign oFHT_WE      = we_q;
  assign oFHT_START   = start_q;
  assign oFHT_ADDR_RD = addr_rd_q;
  assign oBUSY        = (state_q != StIdle);
  assign oOVERRUN     = ovr_q;
  assign oFRAME_CNT   = frame_q;

endmodule

// File: doc/fht_frame_ctrl.md
Name: fht_frame_ctrl

Overview:
- Frame-level sequencer wrapped around fht_top.
- Collects a stream of ADC samples into the four FHT RAM banks, pulses the transform start, and waits for completion.
- After completion it reads the result banks and serialises them as a valid/ready stream in natural index order.
- Replaces bench-driven loading and readout, so that fht_top can run continuously in the system.

Parameters:
- A_BIT, 8: bank address width; BANK_SIZE = 2**A_BIT; frame N = 4*BANK_SIZE.
- D_BIT, 16: FHT word width; ADC samples are D_BIT-1 bits.
- RD_LAT, 2: cycles from oFHT_ADDR_RD change to valid iFHT_DATA_x.
- BANK_REV, 1: 1 = bank select is bit-reversed sample index LSBs {k[0],k[1]}; 0 = k[1:0].

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  synchronous, active-high reset.
- iEN  in  1  permit new frames; sampled only in IDLE and at end of readout.
- iADC_DATA  in  D_BIT-1  signed sample.
- iADC_VALID  in  1  sample strobe.
- iCLR_OVR  in  1  clears oOVERRUN.
- oFHT_DATA  out  D_BIT-1  to fht_top iDATA.
- oFHT_ADDR_WR  out  A_BIT  to iADDR_WR.
- oFHT_WE  out  4  one-hot bank write enables.
- oFHT_START  out  1  one-cycle start pulse.
- iFHT_RDY  in  1  fht_top oRDY; high = idle or done.
- oFHT_ADDR_RD  out  A_BIT  drives all four iADDR_RD_x.
- iFHT_DATA_0..3  in  D_BIT each  bank read data.
- oDATA  out  D_BIT  result word.
- oDATA_VALID  out  1  result handshake valid.
- iDATA_READY  in  1  result handshake ready.
- oLAST  out  1  marks word N-1.
- oBUSY  out  1  high in any state other than IDLE.
- oOVERRUN  out  1  sticky dropped-sample flag.
- oFRAME_CNT  out  16  completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (synchronous, iRESET=1 at an edge): state IDLE; sample counter k=0; all outputs 0. This applies mid-frame too: oFHT_WE and oFHT_START are 0 on the following cycle, and a partial frame is discarded.
- IDLE -> LOAD when iEN=1.
- LOAD:
  - Each iADC_VALID registers the sample (1-cycle latency): oFHT_DATA = sample, oFHT_ADDR_WR = k>>2, oFHT_WE = one-hot(bank(k)). k then increments.
  - When the sample with k = N-1 is written, go to START and set k=0.
  - With iADC_VALID=0, WE=0 and k holds.
- START: oFHT_START=1 for exactly one cycle -> WAIT_LO.
- WAIT_LO: wait for iFHT_RDY=0, then -> WAIT_HI.
  - If RDY stays high for 4 cycles, treat it as an immediate finish -> WAIT_HI.
- WAIT_HI: on iFHT_RDY=1 -> RD_ISSUE; oFRAME_CNT increments in the same cycle.
- Readout:
  - RD_ISSUE: drive oFHT_ADDR_RD = a (a starts at 0) -> RD_WAIT.
  - RD_WAIT: hold for RD_LAT cycles, then capture all four bank words into holding registers -> RD_SHIFT.
  - RD_SHIFT: present holding word b (b = 0..3, mapped through the same bank function as LOAD, so output index j = 4a + b matches the load order). Advance b only on oDATA_VALID & iDATA_READY. oDATA and oDATA_VALID hold stable while ready is low.
  - After b=3 transfers: a+1 -> RD_ISSUE.
  - After a = BANK_SIZE-1: oLAST=1 on the final word. Once it transfers, go to LOAD if iEN=1, else IDLE.
- Overrun: iADC_VALID=1 in any state except LOAD drops the sample and sets oOVERRUN. The flag clears only on iCLR_OVR or reset. If iCLR_OVR and a new drop coincide, set wins.
- oFHT_WE is never asserted outside LOAD. oFHT_START is never asserted outside START.
- Width rule: samples pass unmodified (no sign extension); fht_top performs bit expansion.

Decomposition:
- fht_ctrl_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT_LO, WAIT_HI, RD_ISSUE, RD_WAIT, RD_SHIFT);
  - bank_map function (BANK_REV handling);
  - RDY timeout constant (4).
- Sub-module fht_rd_serializer: 4-word holding register plus valid/ready shifter with oLAST generation. Its interface is load, 4 words, last_group, oDATA/VALID/READY, and done.

Test Plan:
- Basic frame (A_BIT=8, BANK_REV=0): 1024 samples k=0..1023, value = k-512, continuous valid.
  - Sample 5 -> WE=4'b0010, ADDR_WR=1.
  - One START pulse, 1 cycle after sample 1023 is written.
- Bank reversal (BANK_REV=1): sample 1 -> WE=4'b0100; sample 2 -> WE=4'b0010.
- Readout with stub FHT returning bank b, addr a data = 4a+b; iDATA_READY toggled 50%:
  - 1024 words emitted, values 0..1023 in order, oLAST only on 1023;
  - oDATA held stable while READY=0;
  - oFRAME_CNT=1.
- Overrun: ADC_VALID pulse during WAIT_HI -> oOVERRUN=1, no WE asserted; iCLR_OVR -> 0 next cycle.
- Mid-operation reset: iRESET in LOAD at k=300 -> next cycle WE=0, oBUSY=0; the following frame starts at ADDR_WR=0 with WE on bank 0.
- Continuous mode: iEN=1 held for 3 frames -> 3 START pulses, oFRAME_CNT=3, controller returns to LOAD after each oLAST.
